if_stage: RTL
=============

Name: if_stage

Overview:
- Instruction-fetch stage of the team's MIPS CPU; sits directly upstream of the NOP/stall hazard unit and feeds it the fetched instruction.
- Owns the PC register, drives the instruction-memory address and holds the IF/ID pipeline register.
- Consumes the hazard unit's PC-enable and bubble-insert outputs, plus branch/jump redirects resolved downstream.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.
- FLUSH_SLOTS, 1, bubbles injected per redirect (1..7); the redirect cycle counts as the first.
- NOP_WORD, 32'h0000_0000, encoding written into IF/ID as a bubble (sll $0,$0,0).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- en_reg  in  1  PC enable from the hazard unit; 0 = hold PC.
- nop  in  1  bubble request from the hazard unit.
- redirect  in  1  branch-taken / jump / jr resolved this cycle.
- redirect_pc  in  32  target address, valid while redirect=1.
- imem_addr  out  32  combinational, equals pc.
- imem_data  in  32  combinational instruction read for imem_addr.
- pc  out  32  current PC register.
- ifid_instr  out  32  IF/ID instruction; feeds the hazard unit instr input and the decoder.
- ifid_pc4  out  32  IF/ID PC+PC_STEP.
- ifid_valid  out  1  1 = real instruction, 0 = bubble.
- fetch_state  out  2  00 RUN, 01 HOLD, 10 FLUSH.
- bubble_cnt  out  16  saturating count of bubbles injected since reset.

Behaviour:
- Reset values at the first rising clk with reset=1:
  - pc=RESET_PC, ifid_instr=NOP_WORD, ifid_pc4=0, ifid_valid=0.
  - fetch_state=RUN, flush counter=0, bubble_cnt=0.
- Reset overrides every other input, including mid-FLUSH or mid-redirect.
- imem_addr=pc combinationally; imem_data is sampled in the same cycle, so fetch latency is 1 cycle to IF/ID.
- Per-edge priority, highest first:
  1. reset.
  2. redirect=1:
     - pc<=redirect_pc; IF/ID<=bubble.
     - If FLUSH_SLOTS>1: flush counter<=FLUSH_SLOTS-1 and state<=FLUSH; else state<=RUN.
     - Redirect wins even when en_reg=0 or nop=1.
  3. state FLUSH:
     - IF/ID<=bubble, pc holds, counter decrements.
     - Counter reaching 0 → RUN.
     - A new redirect during FLUSH restarts the sequence from item 2.
  4. nop=1: IF/ID<=bubble, pc holds (regardless of en_reg), state<=HOLD.
  5. en_reg=0 (nop=0): pc and IF/ID hold unchanged, state<=HOLD.
  6. Otherwise:
     - ifid_instr<=imem_data, ifid_pc4<=pc+PC_STEP, ifid_valid<=1.
     - pc<=pc+PC_STEP, state<=RUN.
- Bubble definition: ifid_instr<=NOP_WORD, ifid_valid<=0, ifid_pc4 unchanged.
- bubble_cnt increments by 1 on every edge that writes a bubble; it saturates at 16'hFFFF and never wraps.
- pc arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0 with no flag.
- redirect_pc is used as given; bits [1:0] are not checked or masked.
- HOLD → RUN on the first edge satisfying item 6; no extra latency.
- There is no dependency on X on imem_data while pc holds; the value is ignored in HOLD/FLUSH.

Decomposition:
- Shared package cpu_pkg:
  - fetch_state encodings (ST_RUN, ST_HOLD, ST_FLUSH).
  - NOP_WORD constant.
  - RESET_PC default.
- Natural sub-module: pc_reg (PC register with load/increment/hold control and RESET_PC).
- IF/ID register, FSM and counters stay in if_stage.

Test Plan:
- Reset then 4 free-running cycles, en_reg=1, nop=0, redirect=0, imem returning 32'h2001_0005 → pc 0,4,8,C,10; ifid_pc4 4,8,C,10; ifid_valid=1 from cycle 1; bubble_cnt=0.
- en_reg=0 for 3 cycles at pc=8 → pc stays 8, IF/ID unchanged, fetch_state=01; first cycle with en_reg=1 resumes: pc=C next edge.
- nop=1 with en_reg=1 for 34 cycles (divu stall) → pc frozen, ifid_instr=0, ifid_valid=0 each cycle, bubble_cnt=34.
- redirect=1, redirect_pc=32'h0000_0040 while en_reg=0, FLUSH_SLOTS=3 → pc=40, 3 consecutive bubbles, fetch_state 10,10 then 00; next fetch has ifid_pc4=44.
- reset asserted mid-FLUSH → next edge pc=RESET_PC, fetch_state=00, bubble_cnt=0, ifid_valid=0.
- Preload bubble_cnt near saturation, then 3 more bubbles → bubble_cnt holds 16'hFFFF; separately pc=32'hFFFF_FFFC plus one fetch → pc=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the MIPS pipeline stages.
//   ST_RUN / ST_HOLD / ST_FLUSH : fetch_state encodings driven by if_stage.
//   CPU_NOP_WORD                : bubble encoding (sll $0,$0,0).
//   CPU_RESET_PC                : default PC loaded on reset.
//   CPU_BUBBLE_MAX              : saturation value of the bubble counter.
package cpu_pkg;

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_HOLD  = 2'b01;
    localparam logic [1:0] ST_FLUSH = 2'b10;

    localparam logic [31:0] CPU_NOP_WORD = 32'h0000_0000;
    localparam logic [31:0] CPU_RESET_PC = 32'h0000_0000;

    localparam logic [15:0] CPU_BUBBLE_MAX = 16'hFFFF;

endpackage

// File: rtl/pc_reg.sv
// pc_reg: program-counter register for the fetch stage.
//   i_clk      : rising-edge clock.
//   i_reset    : synchronous active-high reset, loads RESET_PC.
//   i_load     : load i_load_pc (redirect); beats i_inc.
//   i_load_pc  : redirect target, used as given.
//   i_inc      : advance by PC_STEP (modulo 2^32).
//   o_pc       : current PC.
//   o_pc_next  : o_pc + PC_STEP, shared with the IF/ID pc4 field.
// With neither i_load nor i_inc asserted the PC holds.
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [31:0]  RESET_PC = CPU_RESET_PC,
    parameter int unsigned  PC_STEP  = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic [31:0] i_load_pc,
    input  logic        i_inc,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_next
);

    logic [31:0] r_pc;
    logic [31:0] w_pc_next;

    // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 becomes 0.
    assign w_pc_next = r_pc + 32'(PC_STEP);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc <= RESET_PC;
        end else if (i_load) begin
            r_pc <= i_load_pc;
        end else if (i_inc) begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc      = r_pc;
    assign o_pc_next = w_pc_next;

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage. Owns the PC, drives the instruction
// memory address and holds the IF/ID register feeding the hazard unit.
//   i_clk, i_reset    : clock, synchronous active-high reset.
//   i_en_reg          : PC enable from the hazard unit (0 = hold).
//   i_nop             : bubble request from the hazard unit.
//   i_redirect        : branch/jump/jr resolved this cycle.
//   i_redirect_pc     : redirect target.
//   o_imem_addr       : instruction address (= o_pc).
//   i_imem_data       : combinational instruction read for o_imem_addr.
//   o_pc              : current PC.
//   o_ifid_instr      : IF/ID instruction (NOP_WORD when bubbled).
//   o_ifid_pc4        : IF/ID PC+PC_STEP.
//   o_ifid_valid      : 1 = real instruction, 0 = bubble.
//   o_fetch_state     : 00 RUN, 01 HOLD, 10 FLUSH.
//   o_bubble_cnt      : saturating count of bubbles written since reset.
// Edge priority: reset > redirect > FLUSH > nop > !en_reg > fetch.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0]  RESET_PC    = CPU_RESET_PC,
    parameter int unsigned  PC_STEP     = 4,
    parameter int unsigned  FLUSH_SLOTS = 1,
    parameter logic [31:0]  NOP_WORD    = CPU_NOP_WORD
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en_reg,
    input  logic        i_nop,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_data,
    output logic [31:0] o_pc,
    output logic [31:0] o_ifid_instr,
    output logic [31:0] o_ifid_pc4,
    output logic        o_ifid_valid,
    output logic [1:0]  o_fetch_state,
    output logic [15:0] o_bubble_cnt
);

    logic [31:0] w_pc;
    logic [31:0] w_pc_next;

    logic        w_bubble;
    logic        w_fetch;
    logic        w_pc_load;
    logic [1:0]  w_state_d;
    logic [2:0]  w_flush_cnt_d;

    logic [1:0]  r_state;
    logic [2:0]  r_flush_cnt;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pc4;
    logic        r_ifid_valid;
    logic [15:0] r_bubble_cnt;

    pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_load    (w_pc_load),
        .i_load_pc (i_redirect_pc),
        .i_inc     (w_fetch),
        .o_pc      (w_pc),
        .o_pc_next (w_pc_next)
    );

    always_comb begin
        w_bubble      = 1'b0;
        w_fetch       = 1'b0;
        w_pc_load     = 1'b0;
        w_state_d     = r_state;
        w_flush_cnt_d = r_flush_cnt;

        if (i_redirect) begin
            // Redirect beats stalls; the redirect edge is the first flush slot.
            w_pc_load = 1'b1;
            w_bubble  = 1'b1;
            if (FLUSH_SLOTS > 1) begin
                w_flush_cnt_d = 3'(FLUSH_SLOTS - 1);
                w_state_d     = ST_FLUSH;
            end else begin
                w_flush_cnt_d = 3'd0;
                w_state_d     = ST_RUN;
            end
        end else if (r_state == ST_FLUSH) begin
            w_bubble = 1'b1;
            if (r_flush_cnt <= 3'd1) begin
                w_flush_cnt_d = 3'd0;
                w_state_d     = ST_RUN;
            end else begin
                w_flush_cnt_d = r_flush_cnt - 3'd1;
            end
        end else if (i_nop) begin
            w_bubble  = 1'b1;
            w_state_d = ST_HOLD;
        end else if (!i_en_reg) begin
            w_state_d = ST_HOLD;
        end else begin
            w_fetch   = 1'b1;
            w_state_d = ST_RUN;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 3'd0;
        end else begin
            r_state     <= w_state_d;
            r_flush_cnt <= w_flush_cnt_d;
        end
    end

    // IF/ID register; a bubble leaves pc4 untouched.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ifid_instr <= NOP_WORD;
            r_ifid_pc4   <= 32'h0000_0000;
            r_ifid_valid <= 1'b0;
        end else if (w_bubble) begin
            r_ifid_instr <= NOP_WORD;
            r_ifid_valid <= 1'b0;
        end else if (w_fetch) begin
            r_ifid_instr <= i_imem_data;
            r_ifid_pc4   <= w_pc_next;
            r_ifid_valid <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bubble_cnt <= 16'h0000;
        end else if (w_bubble && (r_bubble_cnt != CPU_BUBBLE_MAX)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'h0001;
        end
    end

    assign o_imem_addr   = w_pc;
    assign o_pc          = w_pc;
    assign o_ifid_instr  = r_ifid_instr;
    assign o_ifid_pc4    = r_ifid_pc4;
    assign o_ifid_valid  = r_ifid_valid;
    assign o_fetch_state = r_state;
    assign o_bubble_cnt  = r_bubble_cnt;

endmodule
